// File: rtl/mult_share_arb_if.sv
// Requester-side handshake bundle for mult_share_arb: issue channel (req_*) and
// response channel (rsp_*) for both requesters, packed {req1,req0}.
interface mult_share_arb_if;
   logic [1:0]  req_valid;
   logic [1:0]  req_ready;
   logic [15:0] req_a;
   logic [15:0] req_b;
   logic [1:0]  rsp_valid;
   logic [1:0]  rsp_ready;
   logic [31:0] rsp_data;

   modport master (
      output req_valid, req_a, req_b, rsp_ready,
      input  req_ready, rsp_valid, rsp_data
   );

   modport slave (
      input  req_valid, req_a, req_b, rsp_ready,
      output req_ready, rsp_valid, rsp_data
   );
endinterface

// File: rtl/mult_share_arb.sv
// Shares one registered 8u x 8s multiplier between two requesters: arbitrated issue,
// tagged return into per-requester FIFOs, credit flow control. Macro MULT_ARB_FIXED_PRIO_EN.
module mult_share_arb #(
   parameter int unsigned MULT_LAT   = 1,
   parameter int unsigned FIFO_DEPTH = 2
) (
   input  logic            clk,
   input  logic            rst_n,
   mult_share_arb_if.slave bus,
   output logic [7:0]      mul_n1,
   output logic [7:0]      mul_n2,
   input  logic [15:0]     mul_result
);
   localparam int unsigned TAG_STAGES = MULT_LAT + 1;
   localparam int unsigned PTR_W      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned CNT_W      = $clog2(FIFO_DEPTH + 1);

   logic [1:0]            elig;
   logic [1:0]            grant;
   logic [1:0]            wr_en;
   logic [1:0]            pop;
   logic                  issue;
   logic                  gid;
   logic [CNT_W-1:0]      credit [2];
   logic [CNT_W-1:0]      cnt    [2];
   logic [PTR_W-1:0]      wptr   [2];
   logic [PTR_W-1:0]      rptr   [2];
   logic [15:0]           mem    [2][FIFO_DEPTH];
   logic [TAG_STAGES-1:0] tag_vld;
   logic [TAG_STAGES-1:0] tag_id;

`ifndef MULT_ARB_FIXED_PRIO_EN
   logic last_q;
`endif

   // Grant is combinational and forced low while reset is asserted.
   always_comb begin
      elig  = '0;
      grant = '0;
      for (int i = 0; i < 2; i++) begin
         elig[i] = bus.req_valid[i] && (credit[i] != '0);
      end
`ifdef MULT_ARB_FIXED_PRIO_EN
      if (elig[0]) begin
         grant = 2'b01;
      end else if (elig[1]) begin
         grant = 2'b10;
      end
`else
      case (elig)
         2'b01:   grant = 2'b01;
         2'b10:   grant = 2'b10;
         2'b11:   grant = last_q ? 2'b01 : 2'b10;
         default: grant = 2'b00;
      endcase
`endif
      if (!rst_n) begin
         grant = '0;
      end
   end

   assign bus.req_ready = grant;
   assign issue         = |grant;
   assign gid           = grant[1];

`ifndef MULT_ARB_FIXED_PRIO_EN
   // last_q = requester granted most recently; reset value lets requester 0 win first.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_q <= 1'b1;
      end else if (issue) begin
         last_q <= gid;
      end
   end
`endif

   // Operand registers and the tag pipe aligned with the multiplier latency.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mul_n1  <= '0;
         mul_n2  <= '0;
         tag_vld <= '0;
         tag_id  <= '0;
      end else begin
         if (issue) begin
            mul_n1 <= gid ? bus.req_a[15:8] : bus.req_a[7:0];
            mul_n2 <= gid ? bus.req_b[15:8] : bus.req_b[7:0];
         end
         tag_vld <= {tag_vld[TAG_STAGES-2:0], issue};
         tag_id  <= {tag_id[TAG_STAGES-2:0], gid};
      end
   end

   always_comb begin
      wr_en = '0;
      pop   = '0;
      for (int i = 0; i < 2; i++) begin
         wr_en[i] = tag_vld[TAG_STAGES-1] && (tag_id[TAG_STAGES-1] == 1'(i));
         pop[i]   = bus.rsp_ready[i] && (cnt[i] != '0);
      end
   end

   // Credits track free FIFO slots minus products in flight; FIFO occupancy and pointers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 2; i++) begin
            credit[i] <= CNT_W'(FIFO_DEPTH);
            cnt[i]    <= '0;
            wptr[i]   <= '0;
            rptr[i]   <= '0;
         end
      end else begin
         for (int i = 0; i < 2; i++) begin
            case ({grant[i], pop[i]})
               2'b10:   credit[i] <= credit[i] - CNT_W'(1);
               2'b01:   credit[i] <= credit[i] + CNT_W'(1);
               default: credit[i] <= credit[i];
            endcase
            case ({wr_en[i], pop[i]})
               2'b10:   cnt[i] <= cnt[i] + CNT_W'(1);
               2'b01:   cnt[i] <= cnt[i] - CNT_W'(1);
               default: cnt[i] <= cnt[i];
            endcase
            if (wr_en[i]) begin
               wptr[i] <= wptr[i] + PTR_W'(1);
            end
            if (pop[i]) begin
               rptr[i] <= rptr[i] + PTR_W'(1);
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (wr_en[i]) begin
            mem[i][wptr[i]] <= mul_result;
         end
      end
   end

   always_comb begin
      bus.rsp_valid = '0;
      bus.rsp_data  = '0;
      for (int i = 0; i < 2; i++) begin
         bus.rsp_valid[i] = (cnt[i] != '0);
         if (cnt[i] != '0) begin
            bus.rsp_data[16*i +: 16] = mem[i][rptr[i]];
         end
      end
   end
endmodule

// File: tb/tb_mult_share_arb.sv
// Scoreboard bench for mult_share_arb with a registered 8u x 8s multiplier model (latency 1).
module tb_mult_share_arb;
   localparam int unsigned FD = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic [7:0]  mul_n1;
   logic [7:0]  mul_n2;
   logic [15:0] mul_result;
   logic signed [15:0] mul_sa;
   logic signed [15:0] mul_sb;

   int n_checks = 0;
   int n_fail   = 0;
   int outstanding0 = 0;
   int outstanding1 = 0;
   int lat;
   int g0;
   int resumed;
   logic [15:0] exp_p0;
   logic [15:0] exp_p1;
   logic [15:0] exp_q0 [$];
   logic [15:0] exp_q1 [$];

   mult_share_arb_if bus ();

   mult_share_arb #(.MULT_LAT(1), .FIFO_DEPTH(FD)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .bus        (bus),
      .mul_n1     (mul_n1),
      .mul_n2     (mul_n2),
      .mul_result (mul_result)
   );

   always #5 clk = ~clk;

   // External multiplier: unsigned n1 times signed n2, one register stage.
   assign mul_sa = {8'h00, mul_n1};
   assign mul_sb = {{8{mul_n2[7]}}, mul_n2};
   always @(posedge clk) mul_result <= mul_sa * mul_sb;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h, required %0h", name, act, req);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic clear_sb();
      exp_q0.delete();
      exp_q1.delete();
      outstanding0 = 0;
      outstanding1 = 0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      clear_sb();
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   // Monitor: records handshakes into the scoreboard and checks every popped response.
   always @(negedge clk) begin
      if (rst_n) begin
         if (bus.req_valid[0] && bus.req_ready[0]) begin
            check("credit_bound0", 32'(outstanding0 < int'(FD)), 32'd1);
            outstanding0++;
            exp_q0.push_back(exp_p0);
         end
         if (bus.req_valid[1] && bus.req_ready[1]) begin
            check("credit_bound1", 32'(outstanding1 < int'(FD)), 32'd1);
            outstanding1++;
            exp_q1.push_back(exp_p1);
         end
         if (bus.rsp_valid[0] && bus.rsp_ready[0]) begin
            if (exp_q0.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL rsp0_unexpected: got %0h, required no response", bus.rsp_data[15:0]);
            end else begin
               check("rsp0_data", 32'(bus.rsp_data[15:0]), 32'(exp_q0.pop_front()));
            end
            outstanding0--;
         end
         if (bus.rsp_valid[1] && bus.rsp_ready[1]) begin
            if (exp_q1.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL rsp1_unexpected: got %0h, required no response", bus.rsp_data[31:16]);
            end else begin
               check("rsp1_data", 32'(bus.rsp_data[31:16]), 32'(exp_q1.pop_front()));
            end
            outstanding1--;
         end
         if (!bus.rsp_valid[0]) check("rsp0_empty_data", 32'(bus.rsp_data[15:0]), 32'd0);
         if (!bus.rsp_valid[1]) check("rsp1_empty_data", 32'(bus.rsp_data[31:16]), 32'd0);
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got no end of test, required finish before timeout");
      $fatal(1, "timeout");
   end

   initial begin
      bus.req_valid = '0;
      bus.req_a     = '0;
      bus.req_b     = '0;
      bus.rsp_ready = '0;
      exp_p0        = '0;
      exp_p1        = '0;

      // Reset values, with requests pending to show req_ready is held low.
      #1 rst_n = 1'b0;
      bus.req_valid = 2'b11;
      #2;
      check("rst_req_ready", 32'(bus.req_ready), 32'd0);
      check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      check("rst_rsp_data",  bus.rsp_data, 32'd0);
      check("rst_mul_n1",    32'(mul_n1), 32'd0);
      check("rst_mul_n2",    32'(mul_n2), 32'd0);
      bus.req_valid = 2'b00;
      @(posedge clk);
      #1 rst_n = 1'b1;
      bus.rsp_ready = 2'b11;

      // Single issue and its latency.
      bus.req_a = {8'h00, 8'h55};
      bus.req_b = {8'h00, 8'h55};
      exp_p0    = 16'h1C39;
      bus.req_valid = 2'b01;
      @(negedge clk);
      check("t1_grant", 32'(bus.req_ready), 32'd1);
      @(posedge clk);
      #1 bus.req_valid = 2'b00;
      lat = 0;
      for (int k = 1; k <= 6; k++) begin
         @(negedge clk);
         if (bus.rsp_valid[0]) begin
            lat = k;
            break;
         end
      end
      check("t1_latency", 32'(lat), 32'd3);
      idle(4);
      check("t1_drain0", 32'(exp_q0.size()), 32'd0);

      // Both requesters valid every cycle.
      do_reset();
      bus.req_a = {8'h55, 8'hFF};
      bus.req_b = {8'hFF, 8'h80};
      exp_p0    = 16'h8080;
      exp_p1    = 16'hFFAB;
      bus.req_valid = 2'b11;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
`ifdef MULT_ARB_FIXED_PRIO_EN
         check("t2_grant", 32'(bus.req_ready), 32'd1);
`else
         check("t2_grant", 32'(bus.req_ready), (k % 2 == 0) ? 32'd1 : 32'd2);
`endif
         @(posedge clk);
         #1;
      end
      bus.req_valid = 2'b00;
      idle(8);
      check("t2_drain0", 32'(exp_q0.size()), 32'd0);
      check("t2_drain1", 32'(exp_q1.size()), 32'd0);

      // Requester 0 not popping: credits exhaust, requester 1 takes every slot.
      bus.rsp_ready = 2'b10;
      bus.req_a = {8'hAA, 8'hFF};
      bus.req_b = {8'hAA, 8'h81};
      exp_p0    = 16'h817F;
      exp_p1    = 16'hC6E4;
      bus.req_valid = 2'b11;
      g0 = 0;
      for (int k = 0; k < 14; k++) begin
         @(negedge clk);
         if (bus.req_ready[0]) g0++;
         if (k >= 10) check("t3_stall", 32'(bus.req_ready), 32'd2);
         @(posedge clk);
         #1;
      end
      check("t3_grants0", 32'(g0), 32'(FD));
      bus.rsp_ready = 2'b11;
      resumed = 0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         if (bus.req_ready[0]) begin
            resumed = 1;
            break;
         end
      end
      check("t3_resume", 32'(resumed), 32'd1);
      @(posedge clk);
      #1 bus.req_valid = 2'b00;
      idle(10);
      check("t3_drain0", 32'(exp_q0.size()), 32'd0);
      check("t3_drain1", 32'(exp_q1.size()), 32'd0);

      // Pop and request in the same cycle at zero credit.
      bus.rsp_ready = 2'b10;
      bus.req_a = {8'h00, 8'h12};
      bus.req_b = {8'h00, 8'h34};
      exp_p0    = 16'h03A8;
      bus.req_valid = 2'b01;
      g0 = 0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         if (bus.req_ready[0]) g0++;
         @(posedge clk);
         #1;
      end
      check("t4_grants0", 32'(g0), 32'(FD));
      bus.rsp_ready = 2'b11;
      @(negedge clk);
      check("t4_full", 32'(bus.rsp_valid[0]), 32'd1);
      check("t4_pop_nogrant", 32'(bus.req_ready[0]), 32'd0);
      @(posedge clk);
      #1;
      @(negedge clk);
      check("t4_grant_next", 32'(bus.req_ready[0]), 32'd1);
      @(posedge clk);
      #1 bus.req_valid = 2'b00;
      idle(10);
      check("t4_drain0", 32'(exp_q0.size()), 32'd0);

      // Reset with two products in flight.
      bus.req_a = {8'h55, 8'hFF};
      bus.req_b = {8'hFF, 8'h80};
      exp_p0    = 16'h8080;
      exp_p1    = 16'hFFAB;
      bus.req_valid = 2'b11;
      @(posedge clk);
      #1;
      @(posedge clk);
      #1 bus.req_valid = 2'b11;
      #1 rst_n = 1'b0;
      clear_sb();
      #1;
      check("t5_req_ready", 32'(bus.req_ready), 32'd0);
      check("t5_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      check("t5_rsp_data",  bus.rsp_data, 32'd0);
      check("t5_mul_n1",    32'(mul_n1), 32'd0);
      check("t5_mul_n2",    32'(mul_n2), 32'd0);
      bus.req_valid = 2'b00;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         check("t5_no_stale", 32'(bus.rsp_valid), 32'd0);
      end
      @(posedge clk);
      #1;
      bus.req_a = {8'h00, 8'h00};
      bus.req_b = {8'h7F, 8'h00};
      exp_p1    = 16'h0000;
      bus.req_valid = 2'b10;
      @(negedge clk);
      check("t5_grant", 32'(bus.req_ready), 32'd2);
      @(posedge clk);
      #1 bus.req_valid = 2'b00;
      idle(6);
      check("t5_drain1", 32'(exp_q1.size()), 32'd0);

`ifdef MULT_ARB_FIXED_PRIO_EN
      // Fixed priority: requester 0 always wins while eligible.
      bus.req_a = {8'h55, 8'hFF};
      bus.req_b = {8'hFF, 8'h80};
      exp_p0    = 16'h8080;
      exp_p1    = 16'hFFAB;
      bus.req_valid = 2'b11;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         check("t6_prio", 32'(bus.req_ready), 32'd1);
         @(posedge clk);
         #1;
      end
      bus.req_valid = 2'b10;
      @(negedge clk);
      check("t6_req1", 32'(bus.req_ready), 32'd2);
      @(posedge clk);
      #1 bus.req_valid = 2'b00;
      idle(8);
      check("t6_drain0", 32'(exp_q0.size()), 32'd0);
      check("t6_drain1", 32'(exp_q1.size()), 32'd0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
